// File: rtl/coord_stream_feeder_if.sv
// Bundle of the reader-side and merger-side signals of one coord_stream_feeder lane.
//   start      : 1-cycle pulse, begin accepting a new fiber
//   in_valid   : reader has a coordinate on in_coord
//   in_ready   : feeder accepts in_coord this cycle
//   in_coord   : incoming coordinate, sorted ascending within a fiber
//   in_last    : in_coord is the last element of the fiber
//   fetch_next : merger pops the current head
//   coord      : head coordinate, or all-ones sentinel when nothing is buffered
//   head_valid : coord holds a real element
//   fiber_done : last element has been popped
//   underflow  : sticky, pop seen on an empty FIFO while streaming
// The feeder uses the slave modport. The environment (reader + merger) uses the master modport.
interface coord_stream_feeder_if #(
  parameter int unsigned COORD_W = 64
);
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] in_coord;
  logic               in_last;
  logic               fetch_next;
  logic [COORD_W-1:0] coord;
  logic               head_valid;
  logic               fiber_done;
  logic               underflow;

  modport master (
    output start, in_valid, in_coord, in_last, fetch_next,
    input  in_ready, coord, head_valid, fiber_done, underflow
  );

  modport slave (
    input  start, in_valid, in_coord, in_last, fetch_next,
    output in_ready, coord, head_valid, fiber_done, underflow
  );
endinterface

// File: rtl/coord_stream_feeder.sv
// Per-lane input buffer in front of the quaternary merger. It buffers one sorted fiber
// in a small FIFO and presents the FIFO head on coord. The merger pops the head with
// fetch_next. When the FIFO is empty, coord is the all-ones sentinel, so the merger's
// min-select never picks this lane.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : coord_stream_feeder_if.slave (reader handshake, merger head/pop, status)
module coord_stream_feeder #(
  parameter int unsigned COORD_W = 64,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PTR_W   = 2
) (
  input logic                  clock,
  input logic                  reset,
  coord_stream_feeder_if.slave bus
);

  localparam logic [PTR_W:0] DepthCnt = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               underflow_q, underflow_d;
  logic [COORD_W-1:0] coord_mem_q [DEPTH];
  logic               last_mem_q  [DEPTH];

  logic in_ready;
  logic push;
  logic pop;
  logic empty;

  always_comb begin
    empty       = (count_q == '0);
    in_ready    = (state_q == StStream) && (count_q < DepthCnt);
    push        = bus.in_valid && in_ready;
    // A pop on an empty FIFO is dropped: no pointer move.
    pop         = bus.fetch_next && !empty;
    state_d     = state_q;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    if (bus.fetch_next && empty && (state_q == StStream)) begin
      underflow_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d     = StStream;
          underflow_d = 1'b0;
        end
      end
      StStream: begin
        if (push && bus.in_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // The last-flagged entry is the final one in the FIFO. Popping it exhausts the lane.
        if (pop && last_mem_q[rd_ptr_q]) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.start) begin
          state_d     = StStream;
          underflow_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset. count_q gates every read of it.
  always_ff @(posedge clock) begin
    if (push) begin
      coord_mem_q[wr_ptr_q] <= bus.in_coord;
      last_mem_q[wr_ptr_q]  <= bus.in_last;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.coord      = empty ? {COORD_W{1'b1}} : coord_mem_q[rd_ptr_q];
  assign bus.head_valid = !empty;
  assign bus.fiber_done = (state_q == StDone);
  assign bus.underflow  = underflow_q;

endmodule
